// File: rtl/instruction_fetch_unit_pkg.sv
// ============================================================================
// instruction_fetch_unit_pkg: shared types and constants for the fetch unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package instruction_fetch_unit_pkg;

    localparam int ADDRESS_BITS     = 32;
    localparam int LINE_BITS        = 128;
    localparam int LINE_OFFSET_BITS = 4;
    localparam int TAG_BITS         = ADDRESS_BITS - LINE_OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetchState_;

    typedef struct packed {
        logic                 valid;
        logic [TAG_BITS-1:0]  tag;
        logic [LINE_BITS-1:0] data;
    } lineBuffer_;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
// ============================================================================
// instruction_fetch_unit_if: instruction-memory request/response bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_unit_if
    import instruction_fetch_unit_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_BITS,
    parameter int LINE_WIDTH    = LINE_BITS
);
    logic                     memRequest;
    logic [ADDRESS_WIDTH-1:0] memAddress;
    logic                     memReady;
    logic                     memResponseValid;
    logic [LINE_WIDTH-1:0]    memResponseData;
    logic                     memResponseError;

    modport master (
        output memRequest,
        output memAddress,
        input  memReady,
        input  memResponseValid,
        input  memResponseData,
        input  memResponseError
    );

    modport slave (
        input  memRequest,
        input  memAddress,
        output memReady,
        output memResponseValid,
        output memResponseData,
        output memResponseError
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// instruction_fetch_unit: line fetch with single-line hit buffer and redirect squash.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_BITS,
    parameter int LINE_WIDTH    = LINE_BITS
) (
    input  wire                      clock,
    input  wire                      reset,
    input  wire                      redirect,
    input  wire                      invalidateLine,
    input  wire  [ADDRESS_WIDTH-1:0] alignedAddress,
    output logic [LINE_WIDTH-1:0]    instructionFetchData,
    output logic                     instructionFetchDataValid,
    output logic                     instructionFetchFault,
    output logic [ADDRESS_WIDTH-1:0] instructionFetchAddress,
    instruction_fetch_unit_if.master mem
);

    fetchState_          r_state, w_state_next;
    logic [TAG_BITS-1:0] r_pending_tag, w_pending_tag_next;
    logic                r_squash, w_squash_next;
    lineBuffer_          r_buffer, w_buffer_next;

    logic                  r_valid, w_valid_next;
    logic                  r_fault, w_fault_next;
    logic [LINE_WIDTH-1:0] r_data, w_data_next;
    logic [TAG_BITS-1:0]   r_fetch_tag, w_fetch_tag_next;

    logic [TAG_BITS-1:0] w_line_tag;
    logic                w_hit;
    logic                w_accept;
    logic                w_unused_offset;

    assign w_line_tag      = alignedAddress[ADDRESS_WIDTH-1:LINE_OFFSET_BITS];
    assign w_unused_offset = &{1'b0, alignedAddress[LINE_OFFSET_BITS-1:0]};
    assign w_hit           = r_buffer.valid && (r_buffer.tag == w_line_tag);
    assign w_accept        = mem.memRequest && mem.memReady;

    assign mem.memRequest = (r_state == REQUEST);
    assign mem.memAddress = {r_pending_tag, {LINE_OFFSET_BITS{1'b0}}};

    assign instructionFetchData      = r_data;
    assign instructionFetchDataValid = r_valid;
    assign instructionFetchFault     = r_fault;
    assign instructionFetchAddress   = {r_fetch_tag, {LINE_OFFSET_BITS{1'b0}}};

    always_comb begin
        w_state_next       = r_state;
        w_pending_tag_next = r_pending_tag;
        w_squash_next      = r_squash;
        w_buffer_next      = r_buffer;
        w_valid_next       = 1'b0;
        w_fault_next       = 1'b0;
        w_data_next        = r_data;
        w_fetch_tag_next   = r_fetch_tag;

        case (r_state)
            IDLE: begin
                if (redirect) begin
                    w_state_next = IDLE;
                end else if (w_hit) begin
                    w_valid_next     = 1'b1;
                    w_data_next      = r_buffer.data;
                    w_fetch_tag_next = r_buffer.tag;
                end else begin
                    w_pending_tag_next = w_line_tag;
                    w_state_next       = REQUEST;
                end
            end
            REQUEST: begin
                // The request cannot be withdrawn, so a redirect only marks its response stale.
                if (w_accept) begin
                    w_state_next = (r_squash || redirect) ? DISCARD : WAIT;
                end else if (redirect) begin
                    w_squash_next = 1'b1;
                end
            end
            WAIT: begin
                if (mem.memResponseValid) begin
                    w_state_next = IDLE;
                    if (!redirect) begin
                        w_valid_next     = 1'b1;
                        w_fetch_tag_next = r_pending_tag;
                        if (mem.memResponseError) begin
                            w_fault_next = 1'b1;
                            w_data_next  = '0;
                            if (r_buffer.tag == r_pending_tag) begin
                                w_buffer_next.valid = 1'b0;
                            end
                        end else begin
                            w_data_next   = mem.memResponseData;
                            w_buffer_next = '{valid: 1'b1, tag: r_pending_tag,
                                              data: mem.memResponseData};
                        end
                    end
                end else if (redirect) begin
                    w_state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (mem.memResponseValid) begin
                    w_squash_next = 1'b0;
                    w_state_next  = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // fence.i overrides any fill landing in the same cycle
        if (invalidateLine) begin
            w_buffer_next.valid = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_pending_tag <= '0;
            r_squash      <= 1'b0;
            r_buffer      <= '0;
            r_valid       <= 1'b0;
            r_fault       <= 1'b0;
            r_data        <= '0;
            r_fetch_tag   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pending_tag <= w_pending_tag_next;
            r_squash      <= w_squash_next;
            r_buffer      <= w_buffer_next;
            r_valid       <= w_valid_next;
            r_fault       <= w_fault_next;
            r_data        <= w_data_next;
            r_fetch_tag   <= w_fetch_tag_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// tb_instruction_fetch_unit: directed bench with a pulse scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         redirect;
    logic         invalidateLine;
    logic [31:0]  alignedAddress;
    logic [127:0] instructionFetchData;
    logic         instructionFetchDataValid;
    logic         instructionFetchFault;
    logic [31:0]  instructionFetchAddress;

    instruction_fetch_unit_if mem_bus ();

    instruction_fetch_unit dut (
        .clock                     (clock),
        .reset                     (reset),
        .redirect                  (redirect),
        .invalidateLine            (invalidateLine),
        .alignedAddress            (alignedAddress),
        .instructionFetchData      (instructionFetchData),
        .instructionFetchDataValid (instructionFetchDataValid),
        .instructionFetchFault     (instructionFetchFault),
        .instructionFetchAddress   (instructionFetchAddress),
        .mem                       (mem_bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         fault;
    } pulse_t;

    pulse_t expq[$];
    int     checks = 0;
    int     errors = 0;

    localparam logic [127:0] D1     = 128'hDEAD0001_11111111_22222222_3333BEEF;
    localparam logic [127:0] D2     = 128'h20202020_A5A5A5A5_5A5A5A5A_00002000;
    localparam logic [127:0] D3     = 128'h30303030_01234567_89ABCDEF_00003000;
    localparam logic [127:0] D4     = 128'h40404040_FEDCBA98_76543210_00004000;
    localparam logic [127:0] D5     = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] STALE  = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    localparam logic [127:0] STALE2 = 128'hC0FFEE00_C0FFEE00_C0FFEE00_C0FFEE00;

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_pulse(input logic [31:0] a, input logic [127:0] d, input logic f);
        expq.push_back('{a, d, f});
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1 && instructionFetchDataValid === 1'b1) begin
            checks++;
            assert (expq.size() != 0) else begin
                errors++;
                $error("FAIL pulse_expected observed=pulse addr %h expected=no pulse",
                       instructionFetchAddress);
            end
            if (expq.size() != 0) begin
                pulse_t e;
                e = expq.pop_front();
                check("pulse_addr", {96'b0, instructionFetchAddress}, {96'b0, e.addr});
                check("pulse_data", instructionFetchData, e.data);
                check("pulse_fault", {127'b0, instructionFetchFault}, {127'b0, e.fault});
            end
        end
    end

    initial begin
        reset                    = 1'b0;
        redirect                 = 1'b1;
        invalidateLine           = 1'b0;
        alignedAddress           = '0;
        mem_bus.memReady         = 1'b0;
        mem_bus.memResponseValid = 1'b0;
        mem_bus.memResponseData  = '0;
        mem_bus.memResponseError = 1'b0;
        step();
        step();
        check("rst_memRequest", mem_bus.memRequest, 0);
        check("rst_memAddress", mem_bus.memAddress, 0);
        check("rst_valid", instructionFetchDataValid, 0);
        check("rst_fault", instructionFetchFault, 0);
        check("rst_data", instructionFetchData, 0);
        check("rst_addr", instructionFetchAddress, 0);
        reset = 1'b1;

        // Cold miss against zero-wait memory
        alignedAddress   = 32'h0000_1008;
        redirect         = 1'b0;
        mem_bus.memReady = 1'b1;
        step();
        check("miss_memRequest", mem_bus.memRequest, 1);
        check("miss_memAddress", mem_bus.memAddress, 32'h0000_1000);
        step();
        check("wait_no_request", mem_bus.memRequest, 0);
        mem_bus.memReady         = 1'b0;
        mem_bus.memResponseValid = 1'b1;
        mem_bus.memResponseData  = D1;
        expect_pulse(32'h0000_1000, D1, 1'b0);
        step();
        check("miss_pulse_latency", instructionFetchDataValid, 1);

        // Hit on the buffered line
        mem_bus.memResponseValid = 1'b0;
        alignedAddress           = 32'h0000_100C;
        expect_pulse(32'h0000_1000, D1, 1'b0);
        step();
        check("hit_pulse_latency", instructionFetchDataValid, 1);
        check("hit_no_request", mem_bus.memRequest, 0);
        redirect = 1'b1;
        step();
        check("redirect_idle_no_pulse", instructionFetchDataValid, 0);

        // Redirect while waiting; stale response must not fill 0x2000
        alignedAddress   = 32'h0000_2000;
        redirect         = 1'b0;
        mem_bus.memReady = 1'b1;
        step();
        check("req2000_memAddress", mem_bus.memAddress, 32'h0000_2000);
        step();
        mem_bus.memReady = 1'b0;
        redirect         = 1'b1;
        step();
        redirect = 1'b0;
        check("discard_no_request", mem_bus.memRequest, 0);
        repeat (3) step();
        mem_bus.memResponseValid = 1'b1;
        mem_bus.memResponseData  = STALE;
        step();
        check("discard_no_pulse", instructionFetchDataValid, 0);
        mem_bus.memResponseValid = 1'b0;
        step();
        check("refetch_memRequest", mem_bus.memRequest, 1);
        check("refetch_memAddress", mem_bus.memAddress, 32'h0000_2000);
        mem_bus.memReady = 1'b1;
        step();
        mem_bus.memReady         = 1'b0;
        mem_bus.memResponseValid = 1'b1;
        mem_bus.memResponseData  = D2;
        expect_pulse(32'h0000_2000, D2, 1'b0);
        step();
        mem_bus.memResponseValid = 1'b0;
        redirect                 = 1'b1;
        step();

        // Redirect while the request is stalled
        alignedAddress = 32'h0000_6000;
        redirect       = 1'b0;
        step();
        check("stall_req_start", mem_bus.memRequest, 1);
        redirect = 1'b1;
        step();
        redirect       = 1'b0;
        alignedAddress = 32'h0000_2000;
        for (int i = 0; i < 3; i++) begin
            check("stall_memAddress", mem_bus.memAddress, 32'h0000_6000);
            check("stall_memRequest", mem_bus.memRequest, 1);
            if (i == 2) mem_bus.memReady = 1'b1;
            step();
        end
        mem_bus.memReady = 1'b0;
        check("squash_no_request", mem_bus.memRequest, 0);
        mem_bus.memResponseValid = 1'b1;
        mem_bus.memResponseData  = STALE2;
        step();
        mem_bus.memResponseValid = 1'b0;
        expect_pulse(32'h0000_2000, D2, 1'b0);
        step();
        check("buffer_kept_hit", instructionFetchDataValid, 1);

        // Error response and re-request
        alignedAddress   = 32'h0000_3000;
        mem_bus.memReady = 1'b1;
        step();
        check("err_memAddress", mem_bus.memAddress, 32'h0000_3000);
        step();
        mem_bus.memReady         = 1'b0;
        mem_bus.memResponseValid = 1'b1;
        mem_bus.memResponseError = 1'b1;
        mem_bus.memResponseData  = '1;
        expect_pulse(32'h0000_3000, 128'h0, 1'b1);
        step();
        mem_bus.memResponseValid = 1'b0;
        mem_bus.memResponseError = 1'b0;
        step();
        check("err_refetch_memRequest", mem_bus.memRequest, 1);
        check("err_refetch_memAddress", mem_bus.memAddress, 32'h0000_3000);
        mem_bus.memReady = 1'b1;
        step();
        mem_bus.memReady         = 1'b0;
        mem_bus.memResponseValid = 1'b1;
        mem_bus.memResponseData  = D3;
        alignedAddress           = 32'h0000_4000;
        expect_pulse(32'h0000_3000, D3, 1'b0);
        step();

        // invalidateLine coinciding with a fill
        mem_bus.memResponseValid = 1'b0;
        mem_bus.memReady         = 1'b1;
        step();
        check("inv_memAddress", mem_bus.memAddress, 32'h0000_4000);
        step();
        mem_bus.memReady         = 1'b0;
        mem_bus.memResponseValid = 1'b1;
        mem_bus.memResponseData  = D4;
        invalidateLine           = 1'b1;
        expect_pulse(32'h0000_4000, D4, 1'b0);
        step();
        mem_bus.memResponseValid = 1'b0;
        invalidateLine           = 1'b0;
        step();
        check("inv_fill_misses", mem_bus.memRequest, 1);
        check("inv_fill_memAddress", mem_bus.memAddress, 32'h0000_4000);
        mem_bus.memReady = 1'b1;
        step();
        mem_bus.memReady         = 1'b0;
        mem_bus.memResponseValid = 1'b1;
        mem_bus.memResponseData  = D5;
        expect_pulse(32'h0000_4000, D5, 1'b0);
        step();
        mem_bus.memResponseValid = 1'b0;
        redirect                 = 1'b1;
        step();

        // Stand-alone invalidate of a valid line
        invalidateLine = 1'b1;
        step();
        invalidateLine = 1'b0;
        redirect       = 1'b0;
        step();
        check("inv_idle_misses", mem_bus.memRequest, 1);

        // Asynchronous reset in the middle of a request
        #2 reset = 1'b0;
        #1;
        check("async_rst_memRequest", mem_bus.memRequest, 0);
        check("async_rst_memAddress", mem_bus.memAddress, 0);
        check("async_rst_valid", instructionFetchDataValid, 0);
        step();
        step();

        checks++;
        assert (expq.size() == 0) else begin
            errors++;
            $error("FAIL pulses_outstanding observed=%0d expected=0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
